score_display_mux: RTL and testbench
====================================

Name: score_display_mux

Overview:
- Reader of the 16-bit packed BCD score bus {thousands, hundreds, tens, ones} produced by the score tracker.
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display.
- Handles refresh timing, frame-coherent score sampling, leading-zero blanking and invalid-digit blanking.
- Sits between the game logic and the board's seg/an pins.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot; must be >= 2.
- BLINK_TICKS, 256: refresh ticks per blink half-period; used only with SCORE_BLINK_EN.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- score, input, 16: packed BCD {thousands[15:12], hundreds[11:8], tens[7:4], ones[3:0]}.
- game_over, input, 1: game ended; freezes the displayed value.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active low.
- dp, output, 1: decimal point, active low.
- an, output, 4: digit anodes, active low; an[0] = ones … an[3] = thousands.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - Outputs: an = 4'hF, seg = 7'h7F, dp = 1.
  - Internal: prescaler = 0, digit index idx = 0, snapshot = 16'h0000.
- Prescaler:
  - Counts 0 .. REFRESH_DIV-1 and wraps to 0.
  - tick is asserted for exactly one cycle when the count equals REFRESH_DIV-1.
- Digit index:
  - 2-bit idx increments on tick and wraps 3 -> 0.
  - idx 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.
- Snapshot register:
  - Loads score on a tick where idx == 3 (frame boundary), only if game_over == 0.
  - All four digits of one frame therefore always come from a single score value.
  - A score change mid-frame appears from the next frame.
  - Worst-case latency from a score change to display: 4*REFRESH_DIV + 1 cycles.
- Outputs are registered and reflect the current idx and snapshot, one clock after idx changes:
  - an = ~(4'b0001 << idx).
  - seg = decode(snapshot nibble[idx]).
  - dp = 1 always.
- Decode (active low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19.
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Any nibble > 9 decodes to 7F (blank).
- Leading-zero blanking, applied to the snapshot:
  - Thousands is blanked (7F) if it is 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Ones is never blanked, so a score of 0 shows "0".
  - The anode is still driven for blanked digits; only seg = 7F.
- game_over:
  - While high, the snapshot holds its last value and scanning continues.
  - When it falls, the snapshot next loads at the following frame boundary.
- No handshake with the score producer; score is sampled level-wise and is assumed stable in clk domain.

Optional Feature:
- Macro SCORE_BLINK_EN.
- Defined:
  - A blink counter counts refresh ticks while game_over = 1 and toggles a phase bit every BLINK_TICKS ticks.
  - During the off phase, an = 4'hF and seg = 7'h7F.
  - Phase starts "on" when game_over rises.
  - When game_over = 0, the counter clears and the phase resets to "on".
  - Reset clears the counter and the phase.
- Undefined: no blink logic; game_over only freezes the snapshot. BLINK_TICKS is unused.

Test Plan (REFRESH_DIV = 4, BLINK_TICKS = 2):
- Reset held, score = 16'h0000:
  - During reset: an = F, seg = 7F.
  - After release: an cycles 1110, 1101, 1011, 0111, each for 4 clocks.
  - seg = 40 on an[0], 7F on the other three.
- score = 16'h1230 held for 2 frames: in frame 2, an[0] seg = 40, an[1] = 30, an[2] = 24, an[3] = 79.
- score = 16'h0050: an[3] and an[2] seg = 7F, an[1] = 12, an[0] = 40.
- score switches 16'h0010 -> 16'h0990 while idx = 1:
  - Rest of the current frame shows 0010 digits (an[1] = 79).
  - Next frame shows an[1] = 10, an[2] = 10, an[3] = 7F.
- game_over = 1, then score changes 16'h0040 -> 16'h0070: display stays 19 on an[1] across 3 frames.
  - After game_over falls, the next frame shows 78.
- Invalid nibble, score = 16'h00A0: an[1] seg = 7F, an[0] = 40.
- With SCORE_BLINK_EN:
  - game_over = 1: an = F for 2 ticks, then scanning resumes for 2 ticks, repeating.
  - Reset asserted mid-blink: immediately an = F and seg = 7F.
  - After release, the phase is "on".

Source files
------------

// File: rtl/score_display_mux.sv
// score_display_mux: scans a 4-digit packed-BCD score onto a common-anode
// seven-segment display (active-low segments and anodes).
//   - prescaler produces one refresh tick every REFRESH_DIV clocks
//   - 2-bit digit index advances on each tick (0 = ones .. 3 = thousands)
//   - the score is captured once per frame (tick while idx == 3) so that all
//     four digits shown in a frame come from the same score value
//   - leading zeros of the captured score and non-BCD nibbles are blanked
//   - game_over freezes the captured score while scanning continues
// Optional build macro SCORE_BLINK_EN: while game_over is high, the whole
// display blinks with a half-period of BLINK_TICKS refresh ticks.
module score_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score,
    input  logic        game_over,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    // Parameter sanity: the prescaler needs at least two states per slot.
    if (REFRESH_DIV < 2 || BLINK_TICKS < 1) begin : g_bad_params
        $error("score_display_mux: REFRESH_DIV must be >= 2 and BLINK_TICKS >= 1");
    end

    localparam int               CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Segment pattern for one BCD digit, {g,f,e,d,c,b,a} active low.
    // Anything that is not a decimal digit is shown blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    // A digit position is a leading zero when it and every digit above it
    // are zero. The ones digit is never a leading zero so "0" stays visible.
    function automatic logic is_leading_zero(input logic [15:0] value,
                                             input logic [1:0]  pos);
        logic blank;
        case (pos)
            2'd3:    blank = (value[15:12] == 4'd0);
            2'd2:    blank = (value[15:8]  == 8'd0);
            2'd1:    blank = (value[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

    logic [CNT_W-1:0] prescale;
    logic             tick;
    logic [1:0]       idx;
    logic [15:0]      snapshot;
    logic [3:0]       digit_p0;
    logic [6:0]       seg_p0;
    logic [3:0]       an_p0;
    logic             blink_off;

    assign tick = (prescale == CNT_MAX);

    // Refresh prescaler: free-running 0 .. REFRESH_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + CNT_W'(1);
        end
    end

    // Digit index advances once per refresh tick and wraps 3 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Frame-coherent score capture at the frame boundary, frozen by game_over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot <= 16'h0000;
        end else if (tick && idx == 2'd3 && !game_over) begin
            snapshot <= score;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int            BLINK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

    logic [BLINK_W-1:0] blink_cnt;

    // Blink phase: counts ticks only while game_over is high; the phase
    // starts "on" because the counter is held clear while the game runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!game_over) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    // Next segment/anode values for the digit currently selected by idx.
    always_comb begin
        digit_p0 = snapshot[{idx, 2'b00} +: 4];
        an_p0    = ~(4'b0001 << idx);
        if (is_leading_zero(snapshot, idx)) begin
            seg_p0 = 7'h7F;
        end else begin
            seg_p0 = seg_decode(digit_p0);
        end
    end

    // Registered display drive; dark during reset and during the blink-off phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            dp <= 1'b1;
            if (blink_off) begin
                an  <= 4'hF;
                seg <= 7'h7F;
            end else begin
                an  <= an_p0;
                seg <= seg_p0;
            end
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Testbench for score_display_mux (REFRESH_DIV = 4, BLINK_TICKS = 2).
// A cycle-level reference model derived from the frame/slot arithmetic runs
// alongside the DUT; table vectors, hand sequences and random stimulus are
// compared against it and against hand-written constants.
module tb_score_display_mux;
    localparam int DIV   = 4;
    localparam int BLINK = 2;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [3:0] AN_PAT  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] score = 16'h0000;
    logic        game_over = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    score_display_mux #(.REFRESH_DIV(DIV), .BLINK_TICKS(BLINK)) dut (
        .clk(clk), .reset(reset), .score(score), .game_over(game_over),
        .seg(seg), .dp(dp), .an(an)
    );

    // Expected segment pattern for digit position d of a captured value.
    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d);
        int nib;
        nib = int'((v >> (4 * d)) & 16'h000F);
        if (d > 0 && (v >> (4 * d)) == 16'h0000) return 7'h7F;
        if (nib > 9) return 7'h7F;
        return SEG_TBL[nib];
    endfunction

    // Reference model: k counts clock edges since reset release. The slot
    // shown after edge k is floor(k/DIV) mod 4; captures happen on the edges
    // that close a frame (k+1 a multiple of FRAME) while game_over is low.
    int          k;
    int          go_ticks;
    logic [15:0] msnap;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= 0;
            go_ticks <= 0;
            msnap    <= 16'h0000;
            exp_an   <= 4'hF;
            exp_seg  <= 7'h7F;
        end else begin
            int   slot;
            logic off;
            slot = (k / DIV) % 4;
            off  = 1'b0;
`ifdef SCORE_BLINK_EN
            off = ((go_ticks / BLINK) % 2) == 1;
            if (!game_over) go_ticks <= 0;
            else if ((k + 1) % DIV == 0) go_ticks <= go_ticks + 1;
`endif
            exp_an  <= off ? 4'hF : AN_PAT[slot];
            exp_seg <= off ? 7'h7F : ref_seg(msnap, slot);
            if ((k + 1) % FRAME == 0 && !game_over) msnap <= score;
            k <= k + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance n cycles, comparing the outputs with the model at each negedge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("model an", an, exp_an);
            chk("model seg", seg, exp_seg);
            chk("dp", dp, 1);
        end
    endtask

    task automatic wait_an(input logic [3:0] pat, input string name);
        int n = 0;
        while (an !== pat && n < 3 * FRAME) begin
            step(1);
            n++;
        end
        chk(name, an, pat);
    endtask

    // Observe one frame, recording the segments shown for each anode.
    task automatic scan_frame(output logic [3:0][6:0] seen, output logic [3:0] hit);
        seen = '0;
        hit  = '0;
        for (int c = 0; c < FRAME; c++) begin
            step(1);
            for (int d = 0; d < 4; d++) begin
                if (an == AN_PAT[d]) begin
                    seen[d] = seg;
                    hit[d]  = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0]      sc;
        logic [3:0][6:0]  d;   // expected seg for thousands..ones as [3]..[0]
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] seen;
        logic [3:0]      hit;
        logic            f2;
        int              n2;
        int              cnt;

        vecs[0] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[1] = '{16'h1230, {7'h79, 7'h24, 7'h30, 7'h40}};
        vecs[2] = '{16'h0050, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[3] = '{16'h00A0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{16'h0990, {7'h7F, 7'h10, 7'h10, 7'h40}};
        vecs[5] = '{16'h9876, {7'h10, 7'h00, 7'h78, 7'h02}};
        vecs[6] = '{16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
        vecs[7] = '{16'h0305, {7'h7F, 7'h30, 7'h40, 7'h12}};
        vecs[8] = '{16'hF001, {7'h7F, 7'h40, 7'h40, 7'h79}};
        vecs[9] = '{16'h0B00, {7'h7F, 7'h7F, 7'h40, 7'h40}};

        // Reset with score 0
        #2 reset = 1'b1;
        step(3);
        chk("reset an", an, 4'hF);
        chk("reset seg", seg, 7'h7F);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < DIV; c++) begin
                step(1);
                chk($sformatf("post-reset an slot%0d", s), an, AN_PAT[s]);
                chk($sformatf("post-reset seg slot%0d", s), seg, (s == 0) ? 7'h40 : 7'h7F);
            end
        end

        // Table vectors
        for (int v = 0; v < 10; v++) begin
            score = vecs[v].sc;
            step(2 * FRAME);
            scan_frame(seen, hit);
            for (int d = 0; d < 4; d++)
                chk($sformatf("vec%0d digit%0d", v, d), {hit[d], seen[d]}, {1'b1, vecs[v].d[d]});
        end

        // Score change mid-frame (while tens is displayed)
        score = 16'h0010;
        step(2 * FRAME);
        wait_an(4'b1101, "reach tens slot");
        score = 16'h0990;
        f2 = 1'b0;
        n2 = 0;
        for (int c = 0; c < 3 * FRAME && n2 < FRAME; c++) begin
            step(1);
            if (!f2 && an == 4'b1110) f2 = 1'b1;
            if (!f2) begin
                if (an == 4'b1101) chk("switch old tens", seg, 7'h79);
                else               chk("switch old upper", seg, 7'h7F);
            end else begin
                n2++;
                case (an)
                    4'b1110: chk("switch new ones", seg, 7'h40);
                    4'b1101: chk("switch new tens", seg, 7'h10);
                    4'b1011: chk("switch new hundreds", seg, 7'h10);
                    default: chk("switch new thousands", seg, 7'h7F);
                endcase
            end
        end
        chk("switch next frame seen", n2, FRAME);

        // game_over freezes the displayed value
        score = 16'h0040;
        step(2 * FRAME);
        game_over = 1'b1;
        score = 16'h0070;
        for (int f = 0; f < 3; f++) begin
            scan_frame(seen, hit);
`ifdef SCORE_BLINK_EN
            if (hit[1]) chk($sformatf("frozen tens f%0d", f), seen[1], 7'h19);
`else
            chk($sformatf("frozen tens f%0d", f), {hit[1], seen[1]}, {1'b1, 7'h19});
`endif
        end
        game_over = 1'b0;
        step(2 * FRAME);
        scan_frame(seen, hit);
        chk("unfrozen tens", {hit[1], seen[1]}, {1'b1, 7'h78});

        // Asynchronous reset in the middle of a frame
        score = 16'h4321;
        step(2 * FRAME + 5);
        #2 reset = 1'b1;
        #1;
        chk("async reset an", an, 4'hF);
        chk("async reset seg", seg, 7'h7F);
        step(2);
        reset = 1'b0;
        step(1);
        chk("after mid reset an", an, 4'b1110);
        chk("after mid reset seg", seg, 7'h40);

`ifdef SCORE_BLINK_EN
        // Blink while game_over: BLINK ticks off, BLINK ticks on
        score = 16'h0123;
        step(2 * FRAME);
        game_over = 1'b1;
        wait_an(4'hF, "blink off reached");
        cnt = 0;
        while (an == 4'hF && cnt < 4 * FRAME) begin
            chk("blink off seg", seg, 7'h7F);
            step(1);
            cnt++;
        end
        chk("blink off length", cnt, BLINK * DIV);
        cnt = 0;
        while (an != 4'hF && cnt < 4 * FRAME) begin
            step(1);
            cnt++;
        end
        chk("blink on length", cnt, BLINK * DIV);
        #2 reset = 1'b1;
        #1;
        chk("blink reset an", an, 4'hF);
        chk("blink reset seg", seg, 7'h7F);
        step(2);
        reset = 1'b0;
        step(1);
        chk("blink after reset an", an, 4'b1110);
        cnt = 0;
        for (int c = 0; c < BLINK * DIV - 1; c++) begin
            step(1);
            if (an == 4'hF) cnt++;
        end
        chk("blink phase on after reset", cnt, 0);
        game_over = 1'b0;
`endif

        // Random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] r;
                r = 16'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    for (int d = 0; d < 4; d++)
                        r[4*d +: 4] = 4'($urandom_range(0, 9));
                end
                case ($urandom_range(0, 3))
                    0:       r[15:8] = 8'h00;
                    1:       r[15:4] = 12'h000;
                    default: ;
                endcase
                score = r;
            end
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            step(1);
        end
        game_over = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
